// File: rtl/core_pkg.sv
// Core-wide widths and shared payload types used by the front end.
package core_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ISSUE__WIDTH = 2;
  localparam int unsigned FQ_DEPTH     = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_pack.sv
// Compacts the valid fetch slots into the low output slots, keeping slot order.
module fetch_queue_pack
  import core_pkg::*;
#(
  parameter int unsigned FETCH_W = ISSUE__WIDTH
) (
  input  logic [FETCH_W-1:0]          i_valid,
  input  fq_entry_t                   i_entry [FETCH_W-1:0],
  output fq_entry_t                   o_entry [FETCH_W-1:0],
  output logic [$clog2(FETCH_W+1)-1:0] o_n_enq
);

  localparam int unsigned NE_W = $clog2(FETCH_W + 1);

  int w_run;

  // Slot i lands at output index equal to the number of valid slots below it.
  always_comb begin
    w_run = 0;
    for (int k = 0; k < FETCH_W; k++) begin
      o_entry[k] = '0;
    end
    for (int i = 0; i < FETCH_W; i++) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (i_valid[i] && (w_run == k)) begin
          o_entry[k] = i_entry[i];
        end
      end
      if (i_valid[i]) begin
        w_run = w_run + 1;
      end
    end
    o_n_enq = NE_W'(w_run);
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order circular buffer decoupling fetch from decode; flushed on redirect.
module fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned FETCH_W = ISSUE__WIDTH,
  parameter int unsigned DEC_W   = ISSUE__WIDTH,
  parameter int unsigned PC_W    = XLEN,
  parameter int unsigned INSTR_W = XLEN,
  parameter int unsigned DEPTH   = FQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [FETCH_W-1:0]           if_valid,
  input  logic [PC_W-1:0]              if_pc    [FETCH_W-1:0],
  input  logic [INSTR_W-1:0]           if_instr [FETCH_W-1:0],
  output logic                         stall,
  output logic [DEC_W-1:0]             dq_valid,
  output logic [PC_W-1:0]              dq_pc    [DEC_W-1:0],
  output logic [INSTR_W-1:0]           dq_instr [DEC_W-1:0],
  input  logic                         dec_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow_err
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned CALC_W = CNT_W + 1;
  localparam int unsigned NE_W   = $clog2(FETCH_W + 1);

  fq_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  fq_entry_t          w_in [FETCH_W-1:0];
  fq_entry_t          w_pk [FETCH_W-1:0];
  logic [NE_W-1:0]    w_n_enq_raw;
  logic [CALC_W-1:0]  w_cnt;
  logic [CALC_W-1:0]  w_n_enq;
  logic [CALC_W-1:0]  w_n_pres;
  logic [CALC_W-1:0]  w_n_deq;
  logic [CALC_W-1:0]  w_free;
  logic [CALC_W-1:0]  w_n_acc;

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      w_in[i].pc    = XLEN'(if_pc[i]);
      w_in[i].instr = XLEN'(if_instr[i]);
    end
  end

  fetch_queue_pack #(
    .FETCH_W (FETCH_W)
  ) u_pack (
    .i_valid (if_valid),
    .i_entry (w_in),
    .o_entry (w_pk),
    .o_n_enq (w_n_enq_raw)
  );

  // Same-cycle dequeue frees space for this cycle's accept limit.
  always_comb begin
    w_cnt    = CALC_W'(r_count);
    w_n_enq  = CALC_W'(w_n_enq_raw);
    w_n_pres = (w_cnt > CALC_W'(DEC_W)) ? CALC_W'(DEC_W) : w_cnt;
    w_n_deq  = dec_ready ? w_n_pres : '0;
    w_free   = CALC_W'(DEPTH) - w_cnt + w_n_deq;
    w_n_acc  = (w_n_enq < w_free) ? w_n_enq : w_free;
    stall    = (CALC_W'(DEPTH) - w_cnt) < CALC_W'(2 * FETCH_W);
  end

  always_comb begin
    for (int d = 0; d < DEC_W; d++) begin
      dq_valid[d] = 1'b0;
      dq_pc[d]    = '0;
      dq_instr[d] = '0;
      if (CALC_W'(d) < w_n_pres) begin
        dq_valid[d] = 1'b1;
        dq_pc[d]    = PC_W'(r_mem[PTR_W'(r_rd_ptr + PTR_W'(d))].pc);
        dq_instr[d] = INSTR_W'(r_mem[PTR_W'(r_rd_ptr + PTR_W'(d))].instr);
      end
    end
  end

  assign count        = r_count;
  assign overflow_err = r_ovf;

  // Storage carries no reset; only accepted packed slots are written.
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      for (int j = 0; j < FETCH_W; j++) begin
        if (CALC_W'(j) < w_n_acc) begin
          r_mem[PTR_W'(r_wr_ptr + PTR_W'(j))] <= w_pk[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= PTR_W'(r_rd_ptr + PTR_W'(w_n_deq));
      r_wr_ptr <= PTR_W'(r_wr_ptr + PTR_W'(w_n_acc));
      r_count  <= CNT_W'(w_cnt + w_n_acc - w_n_deq);
      if (w_n_acc < w_n_enq) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  if_valid;
  logic [31:0] if_pc    [1:0];
  logic [31:0] if_instr [1:0];
  logic        stall;
  logic [1:0]  dq_valid;
  logic [31:0] dq_pc    [1:0];
  logic [31:0] dq_instr [1:0];
  logic        dec_ready;
  logic [3:0]  count;
  logic        overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: queue of {pc, instr}, oldest at index 0.
  logic [63:0] m_q [$];
  bit          m_ovf  = 1'b0;
  bit          m_live = 1'b0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .stall        (stall),
    .dq_valid     (dq_valid),
    .dq_pc        (dq_pc),
    .dq_instr     (dq_instr),
    .dec_ready    (dec_ready),
    .count        (count),
    .overflow_err (overflow_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n;
    int pres;
    n    = m_q.size();
    pres = (n > 2) ? 2 : n;
    chk("count", 64'(count), 64'(n));
    chk("stall", 64'(stall), 64'((8 - n) < 4));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    for (int d = 0; d < 2; d++) begin
      chk("dq_valid", 64'(dq_valid[d]), 64'(d < pres));
      chk("dq_pc", 64'(dq_pc[d]), (d < pres) ? 64'(m_q[d][63:32]) : 64'd0);
      chk("dq_instr", 64'(dq_instr[d]), (d < pres) ? 64'(m_q[d][31:0]) : 64'd0);
    end
  endtask

  task automatic model_step();
    int pres;
    int free;
    if (!reset) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_live = 1'b1;
    end else if (flush) begin
      m_q.delete();
    end else begin
      pres = (m_q.size() > 2) ? 2 : m_q.size();
      if (dec_ready) begin
        for (int k = 0; k < pres; k++) void'(m_q.pop_front());
      end
      free = 8 - m_q.size();
      for (int i = 0; i < 2; i++) begin
        if (if_valid[i]) begin
          if (free > 0) begin
            m_q.push_back({if_pc[i], if_instr[i]});
            free--;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_cycle(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] i0, input logic [31:0] i1,
                          input logic dr, input logic fl, input logic rs);
    if_valid    = v;
    if_pc[0]    = p0;
    if_pc[1]    = p1;
    if_instr[0] = i0;
    if_instr[1] = i1;
    dec_ready   = dr;
    flush       = fl;
    reset       = rs;
    @(negedge clk);
    if (m_live) check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dr);
    do_cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, dr, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] ins;
    logic        dr;

    // Reset.
    do_cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dq_valid", 64'(dq_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);

    // Fill to full, then one group more is dropped.
    for (int g = 0; g < 5; g++) begin
      ins = 32'h11111111;
      do_cycle(2'b11, 32'(g * 8), 32'(g * 8 + 4),
               ins * 32'(2 * g + 1), ins * 32'(2 * g + 2), 1'b0, 1'b0, 1'b1);
    end
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_ovf", 64'(overflow_err), 64'd1);
    chk("fill_stall", 64'(stall), 64'd1);

    // Drain in order.
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk("drain_count", 64'(count), 64'd0);
    idle(1'b1);

    // Partial slots and compaction.
    do_cycle(2'b10, 32'h0, 32'h14, 32'h0, 32'h66666666, 1'b0, 1'b0, 1'b1);
    chk("part_valid", 64'(dq_valid), 64'd1);
    chk("part_pc0", 64'(dq_pc[0]), 64'h14);
    do_cycle(2'b01, 32'h18, 32'h0, 32'h77777777, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("part_pc1", 64'(dq_pc[1]), 64'h18);
    idle(1'b1);
    idle(1'b1);

    // Fresh reset, then steady enq/deq at count 6 with pointer wrap.
    do_cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++)
      do_cycle(2'b11, 32'(16'h100 + g * 8), 32'(16'h104 + g * 8),
               32'($urandom), 32'($urandom), 1'b0, 1'b0, 1'b1);
    for (int g = 3; g < 9; g++)
      do_cycle(2'b11, 32'(16'h100 + g * 8), 32'(16'h104 + g * 8),
               32'($urandom), 32'($urandom), 1'b1, 1'b0, 1'b1);
    chk("sim_count", 64'(count), 64'd6);
    chk("sim_ovf", 64'(overflow_err), 64'd0);
    chk("wrap_pc0", 64'(dq_pc[0]), 64'h130);

    // Flush at count 5 with traffic in the same cycle.
    do_cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    do_cycle(2'b11, 32'h200, 32'h204, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
    do_cycle(2'b11, 32'h208, 32'h20C, 32'h3, 32'h4, 1'b0, 1'b0, 1'b1);
    do_cycle(2'b01, 32'h210, 32'h0, 32'h5, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("pre_flush_count", 64'(count), 64'd5);
    do_cycle(2'b11, 32'h300, 32'h304, 32'h6, 32'h7, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_dq_valid", 64'(dq_valid), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    do_cycle(2'b11, 32'h08, 32'h0C, 32'h8, 32'h9, 1'b0, 1'b0, 1'b1);
    chk("post_flush_pc0", 64'(dq_pc[0]), 64'h08);
    chk("post_flush_pc1", 64'(dq_pc[1]), 64'h0C);

    // Random traffic with drifting decode-ready bias.
    for (int c = 0; c < 1500; c++) begin
      case ((c / 250) % 3)
        0:       dr = ($urandom_range(0, 3) != 0);
        1:       dr = ($urandom_range(0, 3) == 0);
        default: dr = $urandom_range(0, 1) == 1;
      endcase
      do_cycle(2'($urandom), $urandom, $urandom, $urandom, $urandom, dr,
               $urandom_range(0, 31) == 0, $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
